// File: rtl/mix_heat_sequencer_if.sv
// rtl/mix_heat_sequencer_if.sv - lane request/duration inputs and valve/status outputs
interface mix_heat_sequencer_if #(
  parameter int NUM_SRC = 4,
  parameter int CNT_W   = 16
);
  localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] req;
  logic               abort;
  logic [CNT_W-1:0]   fill_cyc;
  logic [CNT_W-1:0]   mix_cyc;
  logic [CNT_W-1:0]   heat_cyc;
  logic [CNT_W-1:0]   drain_cyc;

  logic [NUM_SRC-1:0] src_valve;
  logic               mix_valve;
  logic               heat_en;
  logic               drain_valve;
  logic [ID_W-1:0]    grant_id;
  logic               busy;
  logic               done;
  logic               aborted;

  // Requesting side: sources and recipe timing.
  modport master (
    output req, abort, fill_cyc, mix_cyc, heat_cyc, drain_cyc,
    input  src_valve, mix_valve, heat_en, drain_valve, grant_id, busy, done, aborted
  );

  // Sequencer side.
  modport slave (
    input  req, abort, fill_cyc, mix_cyc, heat_cyc, drain_cyc,
    output src_valve, mix_valve, heat_en, drain_valve, grant_id, busy, done, aborted
  );
endinterface

// File: rtl/mix_heat_sequencer.sv
// rtl/mix_heat_sequencer.sv - round-robin shared fill/mix/heat/drain lane sequencer
module mix_heat_sequencer #(
  parameter int NUM_SRC = 4,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mix_heat_sequencer_if.slave  lane
);
  localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_MIX, S_HEAT, S_DRAIN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   mix_len_q, mix_len_d;
  logic [CNT_W-1:0]   heat_len_q, heat_len_d;
  logic [CNT_W-1:0]   drain_len_q, drain_len_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    gid_q, gid_d;
  logic               abort_seen_q, abort_seen_d;

  logic [NUM_SRC-1:0] src_q, src_d;
  logic               mixv_q, mixv_d;
  logic               heat_q, heat_d;
  logic               drainv_q, drainv_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;

  logic               found;
  logic [ID_W-1:0]    arb_idx;
  logic [ID_W-1:0]    cand;
  logic               last;
  logic               run_end_abort;

  // Counter reload value: a phase of N cycles counts N-1 down to 0; N=0 behaves as 1.
  function automatic logic [CNT_W-1:0] reload(input logic [CNT_W-1:0] n);
    return (n == '0) ? '0 : n - CNT_W'(1);
  endfunction

  assign last          = (cnt_q == '0);
  assign run_end_abort = abort_seen_q | lane.abort;

  // Round-robin search: first requester at or above the pointer, wrapping.
  always_comb begin
    found   = 1'b0;
    arb_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = ID_W'((int'(ptr_q) + k) % NUM_SRC);
      if (!found && lane.req[cand]) begin
        found   = 1'b1;
        arb_idx = cand;
      end
    end
  end

  // State, timing and datapath registers; outputs are registered alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      mix_len_q    <= '0;
      heat_len_q   <= '0;
      drain_len_q  <= '0;
      ptr_q        <= '0;
      gid_q        <= '0;
      abort_seen_q <= 1'b0;
      src_q        <= '0;
      mixv_q       <= 1'b0;
      heat_q       <= 1'b0;
      drainv_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mix_len_q    <= mix_len_d;
      heat_len_q   <= heat_len_d;
      drain_len_q  <= drain_len_d;
      ptr_q        <= ptr_d;
      gid_q        <= gid_d;
      abort_seen_q <= abort_seen_d;
      src_q        <= src_d;
      mixv_q       <= mixv_d;
      heat_q       <= heat_d;
      drainv_q     <= drainv_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  // Next-state: grant in IDLE, walk phases on counter expiry, abort jumps to DRAIN.
  always_comb begin
    state_d      = state_q;
    cnt_d        = last ? '0 : cnt_q - CNT_W'(1);
    mix_len_d    = mix_len_q;
    heat_len_d   = heat_len_q;
    drain_len_d  = drain_len_q;
    ptr_d        = ptr_q;
    gid_d        = gid_q;
    abort_seen_d = abort_seen_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d      = S_FILL;
          cnt_d        = reload(lane.fill_cyc);
          mix_len_d    = lane.mix_cyc;
          heat_len_d   = lane.heat_cyc;
          drain_len_d  = lane.drain_cyc;
          gid_d        = arb_idx;
          ptr_d        = ID_W'((int'(arb_idx) + 1) % NUM_SRC);
          abort_seen_d = 1'b0;
        end
      end
      S_FILL, S_MIX, S_HEAT: begin
        if (lane.abort) begin
          state_d      = S_DRAIN;
          cnt_d        = reload(drain_len_q);
          abort_seen_d = 1'b1;
        end else if (last) begin
          if (state_q == S_FILL) begin
            state_d = S_MIX;
            cnt_d   = reload(mix_len_q);
          end else if (state_q == S_MIX) begin
            state_d = S_HEAT;
            cnt_d   = reload(heat_len_q);
          end else begin
            state_d = S_DRAIN;
            cnt_d   = reload(drain_len_q);
          end
        end
      end
      S_DRAIN: begin
        if (lane.abort) abort_seen_d = 1'b1;
        if (last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output is a flop.
  always_comb begin
    src_d     = '0;
    mixv_d    = 1'b0;
    heat_d    = 1'b0;
    drainv_d  = 1'b0;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_q == S_DRAIN) && last && !run_end_abort;
    aborted_d = (state_q == S_DRAIN) && last && run_end_abort;
    case (state_d)
      S_FILL: begin
        src_d  = NUM_SRC'(1) << gid_d;
        mixv_d = 1'b1;
      end
      S_HEAT:  heat_d   = 1'b1;
      S_DRAIN: drainv_d = 1'b1;
      default: ;
    endcase
  end

  assign lane.src_valve   = src_q;
  assign lane.mix_valve   = mixv_q;
  assign lane.heat_en     = heat_q;
  assign lane.drain_valve = drainv_q;
  assign lane.grant_id    = gid_q;
  assign lane.busy        = busy_q;
  assign lane.done        = done_q;
  assign lane.aborted     = aborted_q;

  a_valve_excl: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({(|src_q) | mixv_q, heat_q, drainv_q}));

  a_src_in_fill: assert property (@(posedge clk) disable iff (!rst_n)
    (src_q != '0) |-> (state_q == S_FILL));
endmodule

// File: tb/tb_mix_heat_sequencer.sv
// tb/tb_mix_heat_sequencer.sv - directed table and sequence checks for mix_heat_sequencer
module tb_mix_heat_sequencer;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  mix_heat_sequencer_if #(.NUM_SRC(4), .CNT_W(16)) lane_if ();

  mix_heat_sequencer #(.NUM_SRC(4), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .lane  (lane_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Phase codes used in expectations: 0 IDLE, 1 FILL, 2 MIX, 3 HEAT, 4 DRAIN.
  typedef struct {
    bit          rst;
    logic [3:0]  req;
    logic        ab;
    logic [15:0] f, m, h, d;
    int          ph;
    bit          dn;
    bit          abd;
    int          gid;
  } row_t;

  row_t tbl[$];

  localparam logic [15:0] J = 16'd99;

  function automatic row_t mk(bit rst, logic [3:0] req, logic ab,
                              logic [15:0] f, logic [15:0] m, logic [15:0] h, logic [15:0] d,
                              int ph, bit dn, bit abd, int gid);
    row_t r;
    r.rst = rst; r.req = req; r.ab = ab;
    r.f = f; r.m = m; r.h = h; r.d = d;
    r.ph = ph; r.dn = dn; r.abd = abd; r.gid = gid;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(string name, int ph, bit dn, bit abd, int gid);
    logic [3:0] one;
    logic [3:0] exp_src;
    one     = 4'b0001;
    exp_src = (ph == 1) ? (one << gid) : 4'b0000;
    chk({name, " src_valve"},   32'(lane_if.src_valve),   32'(exp_src));
    chk({name, " mix_valve"},   32'(lane_if.mix_valve),   32'(ph == 1));
    chk({name, " heat_en"},     32'(lane_if.heat_en),     32'(ph == 3));
    chk({name, " drain_valve"}, 32'(lane_if.drain_valve), 32'(ph == 4));
    chk({name, " busy"},        32'(lane_if.busy),        32'(ph != 0));
    chk({name, " done"},        32'(lane_if.done),        32'(dn));
    chk({name, " aborted"},     32'(lane_if.aborted),     32'(abd));
    chk({name, " grant_id"},    32'(lane_if.grant_id),    32'(gid));
  endtask

  task automatic set_in(logic [3:0] req, logic ab, logic [15:0] f, logic [15:0] m,
                        logic [15:0] h, logic [15:0] d);
    lane_if.req       = req;
    lane_if.abort     = ab;
    lane_if.fill_cyc  = f;
    lane_if.mix_cyc   = m;
    lane_if.heat_cyc  = h;
    lane_if.drain_cyc = d;
  endtask

  // Called and returns on a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    set_in(4'b0000, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_order[5];
    n_cmp = 0;
    n_bad = 0;

    // T2 single run, durations latched at grant, req dropped mid-run
    tbl.push_back(mk(1, 4'b0100, 0, 16'd3, 16'd2, 16'd4, 16'd2, 1, 0, 0, 2));
    tbl.push_back(mk(0, 4'b0000, 0, J, J, J, J, 1, 0, 0, 2));
    tbl.push_back(mk(0, 4'b0000, 0, J, J, J, J, 1, 0, 0, 2));
    tbl.push_back(mk(0, 4'b0000, 0, J, J, J, J, 2, 0, 0, 2));
    tbl.push_back(mk(0, 4'b0000, 0, J, J, J, J, 2, 0, 0, 2));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 4'b0000, 0, J, J, J, J, 3, 0, 0, 2));
    tbl.push_back(mk(0, 4'b0000, 0, J, J, J, J, 4, 0, 0, 2));
    tbl.push_back(mk(0, 4'b0000, 0, J, J, J, J, 4, 0, 0, 2));
    tbl.push_back(mk(0, 4'b0000, 0, J, J, J, J, 0, 1, 0, 2));
    tbl.push_back(mk(0, 4'b0000, 0, J, J, J, J, 0, 0, 0, 2));
    // T4 abort on 2nd HEAT cycle, full drain, next grant to following source
    tbl.push_back(mk(1, 4'b0010, 0, 16'd2, 16'd2, 16'd3, 16'd3, 1, 0, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 0, J, J, J, J, 1, 0, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 0, J, J, J, J, 2, 0, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 0, J, J, J, J, 2, 0, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 0, J, J, J, J, 3, 0, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 0, J, J, J, J, 3, 0, 0, 1));
    tbl.push_back(mk(0, 4'b1111, 1, J, J, J, J, 4, 0, 0, 1));
    tbl.push_back(mk(0, 4'b1111, 0, J, J, J, J, 4, 0, 0, 1));
    tbl.push_back(mk(0, 4'b1111, 0, J, J, J, J, 4, 0, 0, 1));
    tbl.push_back(mk(0, 4'b1111, 0, J, J, J, J, 0, 0, 1, 1));
    tbl.push_back(mk(0, 4'b1111, 0, J, J, J, J, 1, 0, 0, 2));
    // T5 zero durations: one cycle per phase, done 5 cycles after grant
    tbl.push_back(mk(1, 4'b0001, 0, 16'd0, 16'd0, 16'd0, 16'd0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, J, J, J, J, 2, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, J, J, J, J, 3, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, J, J, J, J, 4, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, J, J, J, J, 0, 1, 0, 0));
    // abort on MIX's last cycle wins over advancing to HEAT
    tbl.push_back(mk(1, 4'b0001, 0, 16'd1, 16'd1, 16'd1, 16'd2, 1, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, J, J, J, J, 2, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 1, J, J, J, J, 4, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, J, J, J, J, 4, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, J, J, J, J, 0, 0, 1, 0));
    // abort in IDLE ignored; abort in DRAIN lets drain finish, then aborted
    tbl.push_back(mk(1, 4'b0001, 1, 16'd1, 16'd1, 16'd1, 16'd2, 1, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, J, J, J, J, 2, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, J, J, J, J, 3, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, J, J, J, J, 4, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 1, J, J, J, J, 4, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, J, J, J, J, 0, 0, 1, 0));

    // T1 reset
    rst_n = 1'b0;
    set_in(4'b0000, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
    @(negedge clk);
    @(negedge clk);
    check_outputs("t1_in_reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    step();
    check_outputs("t1_released", 0, 0, 0, 0);

    // T3 fairness with all requests held, all durations 1
    exp_order = '{0, 1, 2, 3, 0};
    set_in(4'b1111, 1'b0, 16'd1, 16'd1, 16'd1, 16'd1);
    for (int r = 0; r < 5; r++) begin
      step();
      check_outputs($sformatf("t3_run%0d_fill", r), 1, 0, 0, exp_order[r]);
      step();
      check_outputs($sformatf("t3_run%0d_mix", r), 2, 0, 0, exp_order[r]);
      step();
      check_outputs($sformatf("t3_run%0d_heat", r), 3, 0, 0, exp_order[r]);
      step();
      check_outputs($sformatf("t3_run%0d_drain", r), 4, 0, 0, exp_order[r]);
      step();
      check_outputs($sformatf("t3_run%0d_done", r), 0, 1, 0, exp_order[r]);
    end

    // Table-driven runs
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      set_in(tbl[i].req, tbl[i].ab, tbl[i].f, tbl[i].m, tbl[i].h, tbl[i].d);
      step();
      check_outputs($sformatf("row%0d", i), tbl[i].ph, tbl[i].dn, tbl[i].abd, tbl[i].gid);
    end

    // T6 asynchronous reset in MIX, then source 0 has first priority
    do_reset();
    set_in(4'b0100, 1'b0, 16'd1, 16'd4, 16'd1, 16'd1);
    step();
    check_outputs("t6_fill", 1, 0, 0, 2);
    lane_if.req = 4'b0000;
    step();
    check_outputs("t6_mix", 2, 0, 0, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("t6_async", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      check_outputs($sformatf("t6_quiet%0d", c), 0, 0, 0, 0);
    end
    lane_if.req = 4'b1111;
    step();
    check_outputs("t6_regrant", 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
